// File: rtl/sr_ff_pkg.sv
// Shared types for the SR flip-flop bank: invalid-input policy encodings and lock FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sr_ff_pkg;

    // Next-state policy applied to a bit that sees S=R=1 in an accepted command.
    typedef enum logic [1:0] {
        INV_HOLD   = 2'd0,
        INV_SET    = 2'd1,
        INV_RESET  = 2'd2,
        INV_TOGGLE = 2'd3
    } inv_policy_e;

    // Lock FSM states; LOCKED is only reachable when the lock feature is compiled in.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/sr_ff_cell.sv
// One SR flip-flop bit: S/R next-state logic with configurable S=R=1 policy, enable, sync active-low reset.
// Latency: q updates on the rising edge after en=1; no combinational s/r-to-q path.
// Backpressure: none; en gates the update and is driven by the bank's accept strobe.
// Ports: clk, rst (sync, active-low), en, s, r, policy in; q out.
module sr_ff_cell
    import sr_ff_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        s,
    input  logic        r,
    input  inv_policy_e policy,
    output logic        q
);

    logic q_nxt;

    always_comb begin
        q_nxt = q;
        unique case ({s, r})
            2'b10: q_nxt = 1'b1;
            2'b01: q_nxt = 1'b0;
            2'b00: q_nxt = q;
            2'b11: begin
                case (policy)
                    INV_HOLD:   q_nxt = q;
                    INV_SET:    q_nxt = 1'b1;
                    INV_RESET:  q_nxt = 1'b0;
                    INV_TOGGLE: q_nxt = ~q;
                    default:    q_nxt = q;
                endcase
            end
            default: q_nxt = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH SR flip-flops with valid/ready command handshake, sticky per-bit error flags, saturating error counter and irq.
// Latency: one cycle from accepted command to q/err_bit/err_cnt/irq.
// Backpressure: cmd_ready=0 in reset; with SR_FF_BANK_LOCK_EN defined, also 0 while LOCKED after an invalid command until err_clr.
// Ports: clk, rst (sync, active-low), cmd_valid/cmd_ready, s, r, err_clr in; q, qn, err_bit, err_cnt, irq out.
// Optional feature macro: SR_FF_BANK_LOCK_EN (RUN/LOCKED FSM that stalls commands after an invalid one).
module sr_ff_bank
    import sr_ff_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int INV_POLICY = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] err_bit,
    output logic [CNT_W-1:0] err_cnt,
    output logic             irq
);

    localparam inv_policy_e          POLICY  = inv_policy_e'(INV_POLICY[1:0]);
    localparam logic [CNT_W-1:0]     CNT_MAX = '1;

    logic             accept;
    logic             invalid;
    logic [WIDTH-1:0] inv_bits;
    logic [WIDTH-1:0] err_bit_nxt;
    logic [CNT_W-1:0] err_cnt_nxt;

    assign inv_bits = s & r;
    assign invalid  = |inv_bits;
    assign accept   = cmd_valid & cmd_ready;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_ff_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .en     (accept),
            .s      (s[i]),
            .r      (r[i]),
            .policy (POLICY),
            .q      (q[i])
        );
    end

    assign qn = ~q;

    // Clear is applied first so that an error arriving in the same cycle survives it.
    always_comb begin
        err_bit_nxt = err_clr ? '0 : err_bit;
        err_cnt_nxt = err_clr ? '0 : err_cnt;
        if (accept) begin
            err_bit_nxt = err_bit_nxt | inv_bits;
            if (invalid && (err_cnt_nxt != CNT_MAX)) begin
                err_cnt_nxt = err_cnt_nxt + 1'b1;
            end
        end
    end

    // irq is registered from the same next-state as err_bit so the two move together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_bit <= '0;
            err_cnt <= '0;
            irq     <= 1'b0;
        end else begin
            err_bit <= err_bit_nxt;
            err_cnt <= err_cnt_nxt;
            irq     <= |err_bit_nxt;
        end
    end

`ifdef SR_FF_BANK_LOCK_EN
    lock_state_e state;
    lock_state_e state_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (accept && invalid) state_nxt = ST_LOCKED;
            ST_LOCKED: if (err_clr)           state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    assign cmd_ready = rst && (state == ST_RUN);
`else
    assign cmd_ready = rst;
`endif

endmodule

// File: doc/sr_ff_bank.md
SR_FF_BANK -- requirements
Module: sr_ff_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of independent SR flip-flop bits.
REQ-002 Parameter INV_POLICY, default 0, next state on S=R=1: 0 hold, 1 set, 2 reset, 3 toggle.
REQ-003 Parameter CNT_W, default 8, width of the error counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-006 cmd_valid  input  1  the S/R command on s/r is present.
REQ-007 cmd_ready  output  1  block accepts a command this cycle.
REQ-008 s  input  WIDTH  per-bit set request.
REQ-009 r  input  WIDTH  per-bit reset request.
REQ-010 err_clr  input  1  clears sticky error state and releases lock.
REQ-011 q  output  WIDTH  registered flip-flop state.
REQ-012 qn  output  WIDTH  bitwise complement of q.
REQ-013 err_bit  output  WIDTH  sticky per-bit flag, set when that bit received S=R=1.
REQ-014 err_cnt  output  CNT_W  count of accepted commands containing any invalid bit.
REQ-015 irq  output  1  high whenever any err_bit is set.

Function
REQ-016 A command SHALL be accepted only in a cycle with cmd_valid=1 and cmd_ready=1; other cycles leave q unchanged.
REQ-017 On acceptance, each bit i SHALL update at the next edge: S=1,R=0 -> 1; S=0,R=1 -> 0; S=0,R=0 -> hold; S=1,R=1 -> per INV_POLICY.
REQ-018 Latency SHALL be one cycle: q reflects an accepted command at the first edge after acceptance; no combinational s/r-to-q path.
REQ-019 qn SHALL equal ~q in every cycle, including reset.
REQ-020 A command is invalid when (s & r) is nonzero; err_bit SHALL become (err_clr ? 0 : err_bit) | (s & r) on acceptance; new errors win over a simultaneous err_clr.
REQ-021 err_cnt SHALL clear on err_clr, then add 1 for an accepted invalid command in the same cycle; it saturates at 2^CNT_W-1 with no wrap.
REQ-022 Invalid bits SHALL still update q per INV_POLICY; valid bits in the same command SHALL update normally.
REQ-023 irq SHALL be registered, equal to |err_bit, with no extra cycle of delay relative to err_bit.

Reset
REQ-024 With rst=0 at an edge, the block SHALL set q=0, qn=all ones, err_bit=0, err_cnt=0, irq=0, and state RUN; rst overrides any command or err_clr in that cycle.
REQ-025 cmd_ready SHALL be 0 while rst=0 and 1 in the first cycle after reset release.
REQ-026 Reset during LOCKED SHALL return to RUN; no partial command SHALL persist.

Configuration
REQ-027 Macro SR_FF_BANK_LOCK_EN, when defined, SHALL compile in a two-state FSM, RUN and LOCKED.
REQ-028 With SR_FF_BANK_LOCK_EN defined:
- RUN -> LOCKED on acceptance of an invalid command.
- In LOCKED, cmd_ready=0.
- LOCKED -> RUN on err_clr, with cmd_ready=1 the following cycle.
- err_clr in RUN is a pure clear.
REQ-029 Without SR_FF_BANK_LOCK_EN, cmd_ready SHALL be tied to 1 outside reset, and invalid commands SHALL never block acceptance.

Structure
REQ-030 Package sr_ff_pkg SHALL hold the INV_POLICY encodings (HOLD, SET, RESET, TOGGLE) and the lock FSM state type (RUN, LOCKED).
REQ-031 Sub-module sr_ff_cell SHALL implement one bit: next-state logic plus flop with enable, synchronous active-low reset and the policy input.
REQ-032 sr_ff_bank SHALL instantiate sr_ff_cell WIDTH times and hold the handshake, error and lock logic.

Verification
REQ-033 Reset then set/clear: WIDTH=8, command s=0x0F r=0xF0 -> q=0x0F, qn=0xF0 one cycle later; then s=0 r=0 -> q holds 0x0F.
REQ-034 Invalid policy sweep: q=0x0F, command s=0x03 r=0x03 -> q bits[1:0] per policy (hold 0x0F, set 0x0F, reset 0x0C, toggle 0x0C); err_bit=0x03, err_cnt=1, irq=1.
REQ-035 Saturation: CNT_W=2, 5 invalid commands (lock disabled) -> err_cnt reads 1,2,3,3,3.
REQ-036 Simultaneous clear and error: err_bit=0x80, err_clr=1 with accepted s=r=0x01 -> err_bit=0x01, err_cnt=1.
REQ-037 Lock (SR_FF_BANK_LOCK_EN): an invalid command drops cmd_ready; a following valid command is ignored with q unchanged; err_clr restores cmd_ready=1 next cycle; the next command applies.
REQ-038 Reset mid-operation: rst=0 during LOCKED with cmd_valid=1 -> all outputs at reset values, cmd_ready=1 the cycle after release.
